// File: rtl/servo_pwm_ctrl.sv
// Single-channel hobby-servo PWM generator: a free-running frame counter with a
// double-buffered, clamped duty register sampled once per frame at the frame boundary.
module servo_pwm_ctrl #(
  parameter int unsigned PERIOD   = 200000,
  parameter int unsigned DUTY_MIN = 0,
  parameter int unsigned DUTY_MAX = 200000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        pwm_sig,
  input  logic [31:0] pwm_duty_value
);

  localparam logic [31:0] LAST     = 32'(PERIOD - 1);
  localparam logic [32:0] MIN_EXT  = {1'b0, 32'(DUTY_MIN)};
  localparam logic [31:0] MAX_VAL  = 32'(DUTY_MAX);
  localparam logic [32:0] NO_WRAP  = {1'b0, 32'hFFFF_FFFF};

  logic [31:0] cnt;
  logic [31:0] duty_q;
  logic [31:0] cnt_next;
  logic [31:0] duty_next;
  logic [31:0] duty_clamped;
  logic        frame_end;
  logic        below_min;
  logic        above_max;
  logic        pwm_next;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    duty_clamped = pwm_duty_value;
    // A 33-bit difference that wraps past 2^32-1 means the request is below DUTY_MIN.
    below_min    = (({1'b0, pwm_duty_value}) - MIN_EXT) > NO_WRAP;
    above_max    = pwm_duty_value > MAX_VAL;
    if (below_min) begin
      duty_clamped = 32'(DUTY_MIN);
    end else if (above_max) begin
      duty_clamped = MAX_VAL;
    end

    frame_end = (cnt == LAST);
    cnt_next  = frame_end ? 32'd0 : cnt + 32'd1;
    duty_next = frame_end ? duty_clamped : duty_q;
    // NOTE: the output flop is fed from next-state cnt/duty so pwm_sig lines up with cnt, no extra cycle.
    pwm_next  = (cnt_next < duty_next);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt     <= '0;
      duty_q  <= '0;
      pwm_sig <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      duty_q  <= duty_next;
      pwm_sig <= pwm_next;
    end
  end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Scoreboard bench for servo_pwm_ctrl: two instances (unclamped and clamped) share one
// duty stimulus; expected frame widths are queued by the driver and checked per frame.
module tb_servo_pwm_ctrl;

  localparam int          P     = 1000;
  localparam logic [31:0] MIN_A = 32'd0;
  localparam logic [31:0] MAX_A = 32'd1000;
  localparam logic [31:0] MIN_B = 32'd50;
  localparam logic [31:0] MAX_B = 32'd250;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] duty = '0;
  logic        pwm_a;
  logic        pwm_b;

  always #5 clk = ~clk;

  servo_pwm_ctrl #(.PERIOD(P), .DUTY_MIN(0), .DUTY_MAX(1000)) u_full (
    .clk            (clk),
    .resetn         (rst),
    .pwm_sig        (pwm_a),
    .pwm_duty_value (duty)
  );

  servo_pwm_ctrl #(.PERIOD(P), .DUTY_MIN(50), .DUTY_MAX(250)) u_clamp (
    .clk            (clk),
    .resetn         (rst),
    .pwm_sig        (pwm_b),
    .pwm_duty_value (duty)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int          stim_c   = 0;
  int          mon_c    = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] w    [2];
  int          hi   [2];
  int          bad  [2];
  bit          have [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] clamp(input logic [31:0] x, input logic [31:0] lo,
                                        input logic [31:0] hi_lim);
    if (x < lo) return lo;
    if (x > hi_lim) return hi_lim;
    return x;
  endfunction

  // Drive one cycle's request; the value present during the last cycle of a frame
  // sets the next frame's width.
  task automatic drive(input logic [31:0] d);
    duty = d;
    if (stim_c % P == P - 1) begin
      q_a.push_back(clamp(d, MIN_A, MAX_A));
      q_b.push_back(clamp(d, MIN_B, MAX_B));
    end
    stim_c++;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    stim_c = 0;
    mon_c  = 0;
    have   = '{1'b0, 1'b0};
    q_a.delete();
    q_b.delete();
    q_a.push_back(32'd0);
    q_b.push_back(32'd0);
    mon_en = 1'b1;
  endtask

  // Monitor: one sample per cycle at the falling edge, one verdict pair per completed frame.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        int   pos;
        logic p;
        pos = mon_c % P;
        p   = (k == 0) ? pwm_a : pwm_b;
        if (pos == 0) begin
          check($sformatf("expectation queued inst%0d", k),
                32'((k == 0) ? (q_a.size() > 0) : (q_b.size() > 0)), 32'd1);
          have[k] = 1'b0;
          if (k == 0 && q_a.size() > 0) begin
            w[k] = q_a.pop_front();
            have[k] = 1'b1;
          end
          if (k == 1 && q_b.size() > 0) begin
            w[k] = q_b.pop_front();
            have[k] = 1'b1;
          end
          hi[k]  = 0;
          bad[k] = 0;
        end
        if (have[k]) begin
          if (p === 1'b1) hi[k]++;
          if (p !== (32'(pos) < w[k])) bad[k]++;
          if (pos == P - 1) begin
            check($sformatf("frame width inst%0d", k), 32'(hi[k]), w[k]);
            check($sformatf("pulse shape errors inst%0d", k), 32'(bad[k]), 32'd0);
            have[k] = 1'b0;
          end
        end
      end
      mon_c++;
    end
  end

  initial begin
    logic [31:0] d;
    rst  = 1'b1;
    duty = 32'd100;
    repeat (3) @(posedge clk);
    #1;
    check("reset pwm full", 32'(pwm_a), 32'd0);
    check("reset pwm clamp", 32'(pwm_b), 32'd0);

    release_reset();
    repeat (3 * P) drive(32'd100);
    for (int i = 0; i < 3 * P; i++) drive(32'(100 + i / 100));
    repeat (2 * P) drive(32'd0);
    repeat (3 * P) drive(32'd1000);
    repeat (P) drive(32'd1);
    repeat (P) drive(32'd5000);
    repeat (P) drive(32'd10);

    d = 32'd500;
    for (int i = 0; i < 5 * P; i++) begin
      if ($urandom_range(0, 49) == 0)
        d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1100));
      drive(d);
    end

    // Mid-frame reset while the unclamped output sits in a full-high frame.
    repeat (2 * P + 500) drive(32'd1000);
    check("pre-reset pwm high", 32'(pwm_a), 32'd1);
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    check("async reset drop full", 32'(pwm_a), 32'd0);
    check("async reset drop clamp", 32'(pwm_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset held low", 32'(pwm_a), 32'd0);

    release_reset();
    repeat (3 * P) drive(32'd300);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
